// File: rtl/global_ram_loader_if.sv
// Preload bus between a byte-stream source / config master and the global RAM loader.
// The loader takes the slave modport; the driving side takes master.
interface global_ram_loader_if #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned IN_BYTES = 1,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 20
);
  logic                  cfg_start;
  logic [ADDR_W-1:0]     cfg_base_addr;
  logic [CNT_W-1:0]      cfg_num_words;
  logic                  s_valid;
  logic [8*IN_BYTES-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  busy;
  logic [CNT_W-1:0]      words_written;
  logic                  done;
  logic                  err_short;
  logic                  launch;

  modport slave (
    input  cfg_start, cfg_base_addr, cfg_num_words, s_valid, s_data, s_last,
    output s_ready, wr_en, wr_addr, wr_data, busy, words_written, done, err_short, launch
  );

  modport master (
    output cfg_start, cfg_base_addr, cfg_num_words, s_valid, s_data, s_last,
    input  s_ready, wr_en, wr_addr, wr_data, busy, words_written, done, err_short, launch
  );
endinterface

// File: rtl/global_ram_loader.sv
// Packs a byte stream into DATA_W-bit words (earliest byte in the MSB lane) and writes
// them to consecutive global RAM addresses, then pulses done followed by launch.
module global_ram_loader #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned IN_BYTES = 1,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 20
) (
  input  logic               clk,
  input  logic               reset,
  global_ram_loader_if.slave bus
);

  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned BEAT_W = 8 * IN_BYTES;
  localparam int unsigned BCNT_W = $clog2(LANES + 1);
  localparam int unsigned SH_W   = BCNT_W + 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_DONE   = 2'd2,
    S_LAUNCH = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_num;
  logic [CNT_W-1:0]    r_words;
  logic [DATA_W-1:0]   r_pack;
  logic [BCNT_W-1:0]   r_cnt;
  logic                r_finish;
  logic                r_s_ready;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_busy;
  logic                r_done;
  logic                r_err_short;
  logic                r_launch;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_base_nxt;
  logic [CNT_W-1:0]    w_num_nxt;
  logic [CNT_W-1:0]    w_words_nxt;
  logic [DATA_W-1:0]   w_pack_nxt;
  logic [BCNT_W-1:0]   w_cnt_nxt;
  logic                w_finish_nxt;
  logic                w_s_ready_nxt;
  logic                w_wr_en_nxt;
  logic [ADDR_W-1:0]   w_wr_addr_nxt;
  logic [DATA_W-1:0]   w_wr_data_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_err_short_nxt;
  logic                w_launch_nxt;

  logic                w_accept;
  logic [DATA_W-1:0]   w_shift;
  logic [BCNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]    w_words_inc;
  logic [SH_W-1:0]     w_pad_sh;
  logic                w_word_full;
  logic                w_last_word;

  // Datapath helpers: next pack contents, lane count and zero-pad shift for a partial word
  assign w_accept    = r_s_ready & bus.s_valid;
  assign w_shift     = (r_pack << BEAT_W) | DATA_W'(bus.s_data);
  assign w_cnt_inc   = r_cnt + BCNT_W'(IN_BYTES);
  assign w_words_inc = r_words + CNT_W'(1);
  assign w_pad_sh    = {BCNT_W'(LANES) - w_cnt_inc, 3'b000};
  assign w_word_full = (w_cnt_inc == BCNT_W'(LANES));
  assign w_last_word = bus.s_last | (w_words_inc == r_num);

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_base_nxt      = r_base;
    w_num_nxt       = r_num;
    w_words_nxt     = r_words;
    w_pack_nxt      = r_pack;
    w_cnt_nxt       = r_cnt;
    w_finish_nxt    = r_finish;
    w_s_ready_nxt   = r_s_ready;
    w_wr_en_nxt     = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_err_short_nxt = r_err_short;
    w_launch_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_s_ready_nxt = 1'b0;
        if (bus.cfg_start) begin
          w_base_nxt      = bus.cfg_base_addr;
          w_num_nxt       = bus.cfg_num_words;
          w_words_nxt     = '0;
          w_pack_nxt      = '0;
          w_cnt_nxt       = '0;
          w_finish_nxt    = 1'b0;
          w_err_short_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
          if (bus.cfg_num_words == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt   = S_LOAD;
            w_s_ready_nxt = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (r_finish) begin
          // Final word is on the write port this cycle; hand over to completion
          w_state_nxt   = S_DONE;
          w_done_nxt    = 1'b1;
          w_finish_nxt  = 1'b0;
          w_s_ready_nxt = 1'b0;
        end else if (w_accept) begin
          if (w_word_full || bus.s_last) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = r_base + ADDR_W'(r_words);
            w_wr_data_nxt = w_shift << w_pad_sh;
            w_words_nxt   = w_words_inc;
            w_pack_nxt    = '0;
            w_cnt_nxt     = '0;
            if (w_last_word) begin
              w_finish_nxt  = 1'b1;
              w_s_ready_nxt = 1'b0;
            end
            if (bus.s_last && (w_words_inc < r_num)) begin
              w_err_short_nxt = 1'b1;
            end
          end else begin
            w_pack_nxt = w_shift;
            w_cnt_nxt  = w_cnt_inc;
          end
        end
      end

      S_DONE: begin
        w_s_ready_nxt = 1'b0;
        w_state_nxt   = S_LAUNCH;
        w_launch_nxt  = 1'b1;
      end

      S_LAUNCH: begin
        w_s_ready_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
        w_busy_nxt    = 1'b0;
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_s_ready_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_num       <= '0;
      r_words     <= '0;
      r_pack      <= '0;
      r_cnt       <= '0;
      r_finish    <= 1'b0;
      r_s_ready   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_short <= 1'b0;
      r_launch    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_num       <= w_num_nxt;
      r_words     <= w_words_nxt;
      r_pack      <= w_pack_nxt;
      r_cnt       <= w_cnt_nxt;
      r_finish    <= w_finish_nxt;
      r_s_ready   <= w_s_ready_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err_short <= w_err_short_nxt;
      r_launch    <= w_launch_nxt;
    end
  end

  assign bus.s_ready       = r_s_ready;
  assign bus.wr_en         = r_wr_en;
  assign bus.wr_addr       = r_wr_addr;
  assign bus.wr_data       = r_wr_data;
  assign bus.busy          = r_busy;
  assign bus.words_written = r_words;
  assign bus.done          = r_done;
  assign bus.err_short     = r_err_short;
  assign bus.launch        = r_launch;

endmodule

// File: tb/tb_global_ram_loader.sv
// Directed bench for global_ram_loader: one instance with byte input, one with 4-byte input.
module tb_global_ram_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  global_ram_loader_if #(.DATA_W(128), .IN_BYTES(1), .ADDR_W(32), .CNT_W(20)) if1 ();
  global_ram_loader_if #(.DATA_W(128), .IN_BYTES(4), .ADDR_W(32), .CNT_W(20)) if4 ();

  global_ram_loader #(.DATA_W(128), .IN_BYTES(1), .ADDR_W(32), .CNT_W(20)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );
  global_ram_loader #(.DATA_W(128), .IN_BYTES(4), .ADDR_W(32), .CNT_W(20)) u_dut4 (
    .clk(clk), .reset(reset), .bus(if4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitors, sampled mid-cycle
  int cyc = 0;
  logic [31:0]  wa1[$];
  logic [127:0] wd1[$];
  int           wc1[$];
  int done1 = 0, launch1 = 0, done_cyc1 = 0, launch_cyc1 = 0, acc1 = 0, acc_cyc1 = 0;
  logic [31:0]  wa4[$];
  logic [127:0] wd4[$];
  int           wc4[$];
  int done4 = 0, launch4 = 0, done_cyc4 = 0, launch_cyc4 = 0, acc4 = 0, acc_cyc4 = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (if1.wr_en) begin wa1.push_back(if1.wr_addr); wd1.push_back(if1.wr_data); wc1.push_back(cyc); end
    if (if1.done)   begin done1++;   done_cyc1 = cyc; end
    if (if1.launch) begin launch1++; launch_cyc1 = cyc; end
    if (if1.s_valid && if1.s_ready) begin acc1++; acc_cyc1 = cyc; end
    if (if4.wr_en) begin wa4.push_back(if4.wr_addr); wd4.push_back(if4.wr_data); wc4.push_back(cyc); end
    if (if4.done)   begin done4++;   done_cyc4 = cyc; end
    if (if4.launch) begin launch4++; launch_cyc4 = cyc; end
    if (if4.s_valid && if4.s_ready) begin acc4++; acc_cyc4 = cyc; end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg1(input logic [31:0] b, input logic [19:0] n);
    if1.cfg_start = 1'b1; if1.cfg_base_addr = b; if1.cfg_num_words = n;
    tick();
    if1.cfg_start = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d, input logic last);
    logic rdy;
    rdy = 1'b0;
    if1.s_valid = 1'b1; if1.s_data = d; if1.s_last = last;
    for (int k = 0; k < 50; k++) begin
      rdy = if1.s_ready;
      tick();
      if (rdy) break;
    end
    if (!rdy) chk("send1_accept_timeout", 128'(rdy), 128'd1);
    if1.s_valid = 1'b0; if1.s_last = 1'b0;
  endtask

  task automatic send4(input logic [31:0] d, input logic last);
    logic rdy;
    rdy = 1'b0;
    if4.s_valid = 1'b1; if4.s_data = d; if4.s_last = last;
    for (int k = 0; k < 50; k++) begin
      rdy = if4.s_ready;
      tick();
      if (rdy) break;
    end
    if (!rdy) chk("send4_accept_timeout", 128'(rdy), 128'd1);
    if4.s_valid = 1'b0; if4.s_last = 1'b0;
  endtask

  task automatic wait_launch1(input int target);
    for (int k = 0; k < 100; k++) begin
      if (launch1 >= target) break;
      tick();
    end
    if (launch1 < target) chk("launch1_timeout", 128'(launch1), 128'(target));
  endtask

  task automatic wait_launch4(input int target);
    for (int k = 0; k < 100; k++) begin
      if (launch4 >= target) break;
      tick();
    end
    if (launch4 < target) chk("launch4_timeout", 128'(launch4), 128'(target));
  endtask

  int w0, d0, l0, a0, k, rdy_i;
  logic rdy_after16;

  initial begin
    reset = 1'b1;
    if1.cfg_start = 0; if1.cfg_base_addr = 0; if1.cfg_num_words = 0;
    if1.s_valid = 0; if1.s_data = 0; if1.s_last = 0;
    if4.cfg_start = 0; if4.cfg_base_addr = 0; if4.cfg_num_words = 0;
    if4.s_valid = 0; if4.s_data = 0; if4.s_last = 0;
    repeat (3) tick();

    // Reset state
    chk("rst_wr_en",   128'(if1.wr_en), 0);
    chk("rst_s_ready", 128'(if1.s_ready), 0);
    chk("rst_busy",    128'(if1.busy), 0);
    chk("rst_done",    128'({if1.done, if1.launch, if1.err_short}), 0);
    chk("rst_words",   128'(if1.words_written), 0);
    chk("rst_wr_data", if1.wr_data, 0);
    chk("rst_dut4",    128'({if4.wr_en, if4.s_ready, if4.busy, if4.done, if4.launch}), 0);
    reset = 1'b0;
    tick();

    // Basic pack: 32 bytes into two words at 0x10
    w0 = wa1.size(); d0 = done1; l0 = launch1;
    cfg1(32'h10, 20'd2);
    chk("t1_busy", 128'(if1.busy), 1);
    for (int i = 0; i < 32; i++) send1(8'(i), 1'b0);
    wait_launch1(l0 + 1);
    chk("t1_nwrites", 128'(wa1.size() - w0), 2);
    if (wa1.size() - w0 == 2) begin
      chk("t1_addr0", 128'(wa1[w0]), 128'h10);
      chk("t1_data0", wd1[w0], 128'h000102030405060708090A0B0C0D0E0F);
      chk("t1_addr1", 128'(wa1[w0+1]), 128'h11);
      chk("t1_data1", wd1[w0+1], 128'h101112131415161718191A1B1C1D1E1F);
      chk("t1_latency", 128'(wc1[w0+1]), 128'(acc_cyc1 + 1));
    end
    chk("t1_words",  128'(if1.words_written), 2);
    chk("t1_ndone",  128'(done1 - d0), 1);
    chk("t1_launch_after_done", 128'(launch_cyc1), 128'(done_cyc1 + 1));
    chk("t1_busy_end", 128'(if1.busy), 0);
    chk("t1_err", 128'(if1.err_short), 0);

    // Wide input: four 32-bit beats into one word at 0x5
    w0 = wa4.size(); l0 = launch4;
    if4.cfg_start = 1'b1; if4.cfg_base_addr = 32'h5; if4.cfg_num_words = 20'd1;
    tick();
    if4.cfg_start = 1'b0;
    send4(32'hDEADBEEF, 1'b0);
    send4(32'hCAFECAFE, 1'b0);
    send4(32'hBADC0DE0, 1'b0);
    send4(32'h12345678, 1'b0);
    wait_launch4(l0 + 1);
    chk("t2_nwrites", 128'(wa4.size() - w0), 1);
    if (wa4.size() - w0 == 1) begin
      chk("t2_addr", 128'(wa4[w0]), 128'h5);
      chk("t2_data", wd4[w0], 128'hDEADBEEF_CAFECAFE_BADC0DE0_12345678);
      chk("t2_latency", 128'(wc4[w0]), 128'(acc_cyc4 + 1));
    end
    chk("t2_launch_after_done", 128'(launch_cyc4), 128'(done_cyc4 + 1));
    chk("t2_words", 128'(if4.words_written), 1);

    // Short stream: 20 bytes for a 3-word load
    w0 = wa1.size(); d0 = done1; l0 = launch1;
    cfg1(32'h20, 20'd3);
    for (int i = 0; i < 20; i++) send1(8'(i), (i == 19));
    wait_launch1(l0 + 1);
    chk("t3_nwrites", 128'(wa1.size() - w0), 2);
    if (wa1.size() - w0 == 2) begin
      chk("t3_addr1", 128'(wa1[w0+1]), 128'h21);
      chk("t3_data1", wd1[w0+1], 128'h10111213_00000000_00000000_00000000);
    end
    chk("t3_err",   128'(if1.err_short), 1);
    chk("t3_words", 128'(if1.words_written), 2);
    chk("t3_ndone", 128'(done1 - d0), 1);

    // Overrun: 32 cycles of valid data for a 1-word load
    w0 = wa1.size(); a0 = acc1; l0 = launch1;
    cfg1(32'h40, 20'd1);
    chk("t4_err_cleared", 128'(if1.err_short), 0);
    k = 0; rdy_after16 = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if1.s_valid = 1'b1; if1.s_data = 8'(8'hA0 + k);
      rdy_i = int'(if1.s_ready);
      if (k == 16 && c > 0 && rdy_after16 === 1'b1) rdy_after16 = if1.s_ready;
      tick();
      if (rdy_i != 0) k++;
    end
    if1.s_valid = 1'b0;
    wait_launch1(l0 + 1);
    chk("t4_accepted", 128'(k), 16);
    chk("t4_mon_acc", 128'(acc1 - a0), 16);
    chk("t4_ready_low", 128'(rdy_after16), 0);
    chk("t4_nwrites", 128'(wa1.size() - w0), 1);
    if (wa1.size() - w0 == 1) chk("t4_data", wd1[w0], 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);

    // Zero count: done then launch, no writes
    w0 = wa1.size(); d0 = done1; l0 = launch1;
    cfg1(32'h70, 20'd0);
    wait_launch1(l0 + 1);
    chk("t5_nwrites", 128'(wa1.size() - w0), 0);
    chk("t5_ndone", 128'(done1 - d0), 1);
    chk("t5_launch_after_done", 128'(launch_cyc1), 128'(done_cyc1 + 1));
    chk("t5_words", 128'(if1.words_written), 0);

    // cfg_start while busy is ignored
    w0 = wa1.size(); d0 = done1; l0 = launch1;
    cfg1(32'h50, 20'd1);
    cfg1(32'h99, 20'd0);
    for (int i = 0; i < 16; i++) send1(8'(i), 1'b0);
    wait_launch1(l0 + 1);
    chk("t5b_nwrites", 128'(wa1.size() - w0), 1);
    if (wa1.size() - w0 == 1) begin
      chk("t5b_addr", 128'(wa1[w0]), 128'h50);
      chk("t5b_data", wd1[w0], 128'h000102030405060708090A0B0C0D0E0F);
    end
    chk("t5b_ndone", 128'(done1 - d0), 1);

    // Reset mid-load aborts with no write
    w0 = wa1.size();
    cfg1(32'h60, 20'd2);
    for (int i = 0; i < 10; i++) send1(8'(i), 1'b0);
    reset = 1'b1;
    tick();
    chk("t6_rst_outs", 128'({if1.wr_en, if1.s_ready, if1.busy, if1.done, if1.launch, if1.err_short}), 0);
    chk("t6_rst_words", 128'(if1.words_written), 0);
    reset = 1'b0;
    a0 = acc1;
    if1.s_valid = 1'b1; if1.s_data = 8'h55;
    repeat (20) tick();
    if1.s_valid = 1'b0;
    chk("t6_nwrites", 128'(wa1.size() - w0), 0);
    chk("t6_no_accept", 128'(acc1 - a0), 0);

    // Address wrap
    w0 = wa1.size(); l0 = launch1;
    cfg1(32'hFFFFFFFF, 20'd2);
    for (int i = 0; i < 32; i++) send1(8'(i), 1'b0);
    wait_launch1(l0 + 1);
    chk("t6_wrap_nwrites", 128'(wa1.size() - w0), 2);
    if (wa1.size() - w0 == 2) begin
      chk("t6_wrap_addr0", 128'(wa1[w0]), 128'hFFFFFFFF);
      chk("t6_wrap_addr1", 128'(wa1[w0+1]), 128'h0);
      chk("t6_wrap_data1", wd1[w0+1], 128'h101112131415161718191A1B1C1D1E1F);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/global_ram_loader.md
Name: global_ram_loader

Overview:
- Streams byte-granular preload data into the global BRAM write port of the fused-block top.
- Packs incoming bytes into DATA_W-bit words, first byte in the MSB lane, with no lane duplication or skipping.
- Auto-increments the write address from a programmed base.
- On completion, raises done and then a launch pulse that drives the fused top's start input. This replaces hand-driven testbench preload loops.

Parameters:
- DATA_W, 128, global RAM word width in bits; multiple of 8.
- IN_BYTES, 1, bytes accepted per input beat; must divide DATA_W/8.
- ADDR_W, 32, global RAM address width.
- CNT_W, 20, width of the word-count configuration.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_start  in  1  one-cycle pulse; latches cfg_base_addr and cfg_num_words when idle
- cfg_base_addr  in  ADDR_W  first global RAM word address
- cfg_num_words  in  CNT_W  number of DATA_W words to write
- s_valid  in  1  input beat valid
- s_data  in  8*IN_BYTES  input bytes; byte at [8*IN_BYTES-1 -:8] is earliest in stream order
- s_last  in  1  final beat of stream
- s_ready  out  1  loader accepts a beat this cycle
- wr_en  out  1  global RAM write enable
- wr_addr  out  ADDR_W  global RAM write address
- wr_data  out  DATA_W  packed word
- busy  out  1  high from accepted cfg_start until return to IDLE
- words_written  out  CNT_W  words written in the current or last load
- done  out  1  one-cycle pulse at end of load
- err_short  out  1  sticky until next cfg_start; s_last arrived before cfg_num_words words
- launch  out  1  one-cycle pulse the cycle after done; connects to the fused top's start

Behaviour:
- Reset: all outputs 0; state IDLE; pack register and byte counter cleared. Reset mid-load aborts with no further writes.
- Definitions: LANES = DATA_W/8. A beat is accepted when s_valid and s_ready are both high.
- State IDLE:
  - s_ready = 0.
  - cfg_start latches base and count, clears words_written and err_short, sets busy.
  - Goes to LOAD, or to DONE if cfg_num_words == 0.
- State LOAD:
  - s_ready = 1 except in the cycle a word is being emitted when that word is the last one.
  - Each accepted beat shifts IN_BYTES bytes into the pack register toward the MSB; byte counter advances by IN_BYTES.
  - When the counter reaches LANES: next cycle wr_en = 1, wr_addr = base + words_written, wr_data = packed word. In that same cycle words_written increments and the counter resets. Latency from completing beat to write is 1 cycle.
  - No gaps required: back-to-back beats give one write every LANES/IN_BYTES cycles.
- s_last on a partial word:
  - Remaining lanes are zero-padded and the word is written the next cycle.
  - That word counts toward words_written.
- s_last arriving with words_written (after this beat) < cfg_num_words: set err_short, go to DONE after the pending write.
- Word count reached: go to DONE with s_ready = 0. Any further beats are not accepted and stay pending upstream. s_last on the exact final beat is legal and raises no error.
- State DONE: done = 1 for one cycle, then LAUNCH.
- State LAUNCH: launch = 1 for one cycle, busy cleared, back to IDLE.
- cfg_start while busy is ignored.
- wr_addr wraps modulo 2^ADDR_W.
- wr_en never asserts outside LOAD or the cycle following the last accepted beat.

Test Plan:
- Basic pack: DATA_W=128, IN_BYTES=1, base=0x10, num=2, bytes 0x00..0x1F back-to-back → wr@0x10 = 0x000102…0F, wr@0x11 = 0x101112…1F, done, launch next cycle, words_written=2, no duplicated byte.
- Wide input: IN_BYTES=4, num=1, beats 0xDEADBEEF, 0xCAFECAFE, 0xBADC0DE0, 0x12345678 → single write 0xDEADBEEF_CAFECAFE_BADC0DE0_12345678, one cycle after the 4th beat.
- Short stream: num=3, 20 bytes with s_last on byte 20 → two writes, the second padded as 0x10111213_00…00, err_short=1, done, launch.
- Backpressure/overrun: num=1, 32 valid bytes offered continuously → exactly one write, s_ready low after 16th byte, bytes 17+ not accepted.
- Zero count and ignore: cfg_start with num=0 → done then launch, no wr_en. Second cfg_start while busy → no effect.
- Reset mid-load and wrap: reset after 10 bytes → outputs 0, no write. Then base=0xFFFFFFFF, num=2 → writes at 0xFFFFFFFF then 0x00000000.
